// File: rtl/result_reader_pkg.sv
// Shared definitions for the result dump engine: FSM encoding, word/byte geometry
// and the helpers that split a 12-bit memory word into two transmit bytes.
package result_reader_pkg;

   localparam int ADDR_W   = 12;
   localparam int WORD_W   = 12;
   localparam int CNT_W    = 13;
   localparam int BYTE_W   = 8;
   localparam int HI_BITS  = WORD_W - BYTE_W;
   localparam int HI_PAD_W = BYTE_W - HI_BITS;

   typedef logic [2:0]        state_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [WORD_W-1:0] word_t;
   typedef logic [CNT_W-1:0]  cnt_t;
   typedef logic [BYTE_W-1:0] byte_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_ADDR    = 3'd1;
   localparam state_t ST_WAIT    = 3'd2;
   localparam state_t ST_SEND_HI = 3'd3;
   localparam state_t ST_SEND_LO = 3'd4;
   localparam state_t ST_FIN     = 3'd5;

   function automatic byte_t hi_byte(input word_t w);
      return {{HI_PAD_W{1'b0}}, w[WORD_W-1:BYTE_W]};
   endfunction

   function automatic byte_t lo_byte(input word_t w);
      return w[BYTE_W-1:0];
   endfunction

endpackage

// File: rtl/result_reader.sv
// Dumps count 12-bit words from data memory starting at base_addr as hi/lo byte pairs.
// Per word: 1 address cycle + RD_LAT wait + 2 send cycles; tx_valid holds its byte until tx_ready.
module result_reader
   import result_reader_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  count,
   output logic [ADDR_W-1:0] addr_tb,
   input  logic [WORD_W-1:0] result,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done
);

   localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

   state_t            state;
   word_t             word;
   cnt_t              cnt_q;
   cnt_t              sent;
   logic [WAIT_W-1:0] wait_cnt;
   logic              last_word;

   assign last_word = (sent + 13'd1) == cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         addr_tb  <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         word     <= '0;
         cnt_q    <= '0;
         sent     <= '0;
         wait_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // done is still high the cycle after FIN; a start there is dropped too
               if (start && !done) begin
                  cnt_q <= count;
                  sent  <= '0;
                  busy  <= 1'b1;
                  if (count == '0) begin
                     state <= ST_FIN;
                  end else begin
                     addr_tb <= base_addr;
                     state   <= ST_ADDR;
                  end
               end
            end
            ST_ADDR: begin
               wait_cnt <= '0;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  word     <= result;
                  tx_data  <= hi_byte(result);
                  tx_valid <= 1'b1;
                  state    <= ST_SEND_HI;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_SEND_HI: begin
               if (tx_ready) begin
                  tx_data <= lo_byte(word);
                  state   <= ST_SEND_LO;
               end
            end
            ST_SEND_LO: begin
               if (tx_ready) begin
                  sent     <= sent + 13'd1;
                  tx_valid <= 1'b0;
                  tx_data  <= '0;
                  if (last_word) begin
                     state <= ST_FIN;
                  end else begin
                     addr_tb <= addr_tb + 12'd1;
                     state   <= ST_ADDR;
                  end
               end
            end
            ST_FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state    <= ST_IDLE;
               tx_valid <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: a queue model of the byte stream plus literal pins.
module tb_result_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] base_addr;
   logic [12:0] count;
   logic [11:0] addr_tb;
   logic [11:0] result;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   result_reader #(.RD_LAT(1)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
      .addr_tb(addr_tb), .result(result), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .done(done)
   );

   logic [11:0] mem [0:4095];
   always @(posedge clk) result <= mem[addr_tb];

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0]  exp_q[$];
   logic [11:0] exp_addr_q[$];
   logic [7:0]  log_q[$];
   logic [11:0] addr_log[$];
   int   done_cnt = 0;
   bit   hi_phase = 1'b1;
   logic prev_v = 1'b0, prev_r = 1'b0;
   logic [7:0] prev_d = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Expected stream: every word in address order, high nibble byte then low byte.
   task automatic expect_dump(input logic [11:0] b, input int c);
      logic [11:0] a;
      logic [11:0] w;
      for (int i = 0; i < c; i++) begin
         a = 12'((int'(b) + i) % 4096);
         w = mem[a];
         exp_addr_q.push_back(a);
         exp_q.push_back({4'h0, w[11:8]});
         exp_q.push_back(w[7:0]);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_v   = 1'b0;
         hi_phase = 1'b1;
      end else begin
         if (prev_v && !prev_r) begin
            chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
            chk("tx_hold_data", {24'd0, tx_data}, {24'd0, prev_d});
         end
         if (tx_valid && tx_ready) begin
            log_q.push_back(tx_data);
            if (hi_phase) addr_log.push_back(addr_tb);
            if (exp_q.size() == 0) begin
               fail_now("unexpected_byte");
            end else begin
               chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
               if (hi_phase) chk("word_addr", {20'd0, addr_tb}, {20'd0, exp_addr_q.pop_front()});
            end
            hi_phase = !hi_phase;
         end
         if (done) begin
            done_cnt++;
            chk("busy_at_done", {31'd0, busy}, 32'd0);
         end
         prev_v = tx_valid;
         prev_r = tx_ready;
         prev_d = tx_data;
      end
   end

   // mode: 0 ready high, 1 five-cycle stall on first hi byte, 2 extra start pulses, 3 random ready
   task automatic run_dump(input logic [11:0] b, input int c, input int mode);
      int d0, cyc, stall_left, budget;
      expect_dump(b, c);
      log_q.delete();
      addr_log.delete();
      d0 = done_cnt;
      stall_left = (mode == 1) ? 5 : 0;
      tx_ready = (mode == 1) ? 1'b0 : 1'b1;
      budget = 20 * c + 50;
      base_addr = b;
      count = 13'(c);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = '0;
      count = '0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      cyc = 0;
      while (!done && cyc < budget) begin
         if (mode == 2 && cyc == 3) begin
            start = 1'b1; base_addr = 12'd500; count = 13'd7;
         end else if (mode == 2 && cyc == 4) begin
            start = 1'b0;
         end
         if (mode == 3) tx_ready = 1'($urandom_range(0, 1));
         if (stall_left > 0 && tx_valid) begin
            chk("stall_hi_byte", {24'd0, tx_data}, {28'd0, mem[b][11:8]});
            stall_left--;
            if (stall_left == 0) tx_ready = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (!done) fail_now("done_timeout");
      if (mode == 0) chk("throughput", {31'd0, cyc <= 5 * c + 4}, 32'd1);
      if (mode == 2) begin
         start = 1'b1; base_addr = 12'd7; count = 13'd3;
         @(posedge clk); #1;
         start = 1'b0;
      end
      tx_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("done_pulses", done_cnt - d0, 32'd1);
      chk("bytes_left", exp_q.size(), 32'd0);
      chk("byte_count", log_q.size(), 2 * c);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("tx_valid_after", {31'd0, tx_valid}, 32'd0);
   endtask

   initial begin
      int d0, cyc;
      rst = 1'b1; start = 1'b0; tx_ready = 1'b1; base_addr = '0; count = '0;
      for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
      mem[8] = 12'hABC; mem[9] = 12'h123; mem[4095] = 12'h0F0; mem[0] = 12'h001;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_addr", {20'd0, addr_tb}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      run_dump(12'd8, 2, 0);
      chk("b30_0", {24'd0, log_q[0]}, 32'h0A);
      chk("b30_1", {24'd0, log_q[1]}, 32'hBC);
      chk("b30_2", {24'd0, log_q[2]}, 32'h01);
      chk("b30_3", {24'd0, log_q[3]}, 32'h23);

      run_dump(12'd4095, 2, 0);
      chk("wrap_addr0", {20'd0, addr_log[0]}, 32'd4095);
      chk("wrap_addr1", {20'd0, addr_log[1]}, 32'd0);
      chk("b31_0", {24'd0, log_q[0]}, 32'h00);
      chk("b31_1", {24'd0, log_q[1]}, 32'hF0);
      chk("b31_2", {24'd0, log_q[2]}, 32'h00);
      chk("b31_3", {24'd0, log_q[3]}, 32'h01);

      d0 = done_cnt;
      start = 1'b1; base_addr = 12'd8; count = 13'd0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("zero_done_early", {31'd0, done}, 32'd0);
      chk("zero_tx_valid", {31'd0, tx_valid}, 32'd0);
      @(posedge clk); #1;
      chk("zero_done", {31'd0, done}, 32'd1);
      chk("zero_tx_valid2", {31'd0, tx_valid}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("zero_done_once", done_cnt - d0, 32'd1);

      run_dump(12'd8, 2, 1);
      chk("b33_0", {24'd0, log_q[0]}, 32'h0A);
      chk("b33_1", {24'd0, log_q[1]}, 32'hBC);
      chk("b33_2", {24'd0, log_q[2]}, 32'h01);
      chk("b33_3", {24'd0, log_q[3]}, 32'h23);

      run_dump(12'd8, 2, 2);

      // Reset while the second word's low byte is on the wire.
      expect_dump(12'd8, 2);
      log_q.delete();
      addr_log.delete();
      d0 = done_cnt;
      start = 1'b1; base_addr = 12'd8; count = 13'd2;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (log_q.size() < 3 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (log_q.size() < 3) fail_now("reset_setup_timeout");
      chk("pre_rst_lo_byte", {24'd0, tx_data}, 32'h23);
      rst = 1'b1;
      #1;
      chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_addr", {20'd0, addr_tb}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      exp_q.delete();
      exp_addr_q.delete();
      repeat (6) @(posedge clk);
      #1;
      chk("rst_no_done", done_cnt - d0, 32'd0);
      chk("rst_no_bytes", log_q.size(), 32'd3);
      chk("rst_idle_busy", {31'd0, busy}, 32'd0);
      run_dump(12'd8, 1, 0);
      chk("b34_0", {24'd0, log_q[0]}, 32'h0A);
      chk("b34_1", {24'd0, log_q[1]}, 32'hBC);

      run_dump(12'd4000, 200, 3);
      run_dump(12'd100, 4096, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
